// File: rtl/ram_sp_arbiter.sv
// Two-master arbiter and sequencer for the single-port data RAM (M0 = fetch, M1 = load/store).
// One transaction runs at a time over four cycles; every RAM pin is driven from a flop.
module ram_sp_arbiter #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 16,
    parameter int ARB_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] ram_add,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_r_w,
    output logic              ram_enable,
    output logic              ram_ce,
    input  logic [DATA_W-1:0] ram_data_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

    state_t state;
    state_t next_state;
    logic   last_grant;
    logic   owner;
    logic   any_req;
    logic   pick_m1;

    assign any_req = m0_req | m1_req;
    assign ram_ce  = ram_enable;

    // Winner selection; only consulted in IDLE when at least one request is up.
    // last_grant = 1 means M1 was served last, so M0 wins the next tie.
    always_comb begin
        pick_m1 = 1'b0;
        if (ARB_MODE == 1)
            pick_m1 = !m0_req;
        else
            pick_m1 = m1_req && (!m0_req || !last_grant);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = ACCESS;
            ACCESS:  next_state = CAPTURE;
            CAPTURE: next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The RAM pins double as the latched transaction: they are loaded once at the
    // grant edge and ignore the masters' inputs until the transaction retires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_gnt      <= 1'b0;
            m1_gnt      <= 1'b0;
            m0_done     <= 1'b0;
            m1_done     <= 1'b0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
            ram_add     <= '0;
            ram_data_in <= '0;
            ram_r_w     <= 1'b0;
            ram_enable  <= 1'b0;
            owner       <= 1'b0;
            last_grant  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner       <= pick_m1;
                        m0_gnt      <= !pick_m1;
                        m1_gnt      <= pick_m1;
                        ram_r_w     <= pick_m1 ? m1_we    : m0_we;
                        ram_add     <= pick_m1 ? m1_addr  : m0_addr;
                        ram_data_in <= pick_m1 ? m1_wdata : m0_wdata;
                        ram_enable  <= 1'b1;
                    end else begin
                        ram_r_w     <= 1'b0;
                        ram_add     <= '0;
                        ram_data_in <= '0;
                        ram_enable  <= 1'b0;
                    end
                end
                ACCESS: begin
                    ram_enable <= 1'b0;
                end
                CAPTURE: begin
                    if (owner) begin
                        m1_done <= 1'b1;
                        if (!ram_r_w) m1_rdata <= ram_data_out;
                    end else begin
                        m0_done <= 1'b1;
                        if (!ram_r_w) m0_rdata <= ram_data_out;
                    end
                end
                DONE: begin
                    m0_done     <= 1'b0;
                    m1_done     <= 1'b0;
                    m0_gnt      <= 1'b0;
                    m1_gnt      <= 1'b0;
                    last_grant  <= owner;
                    ram_r_w     <= 1'b0;
                    ram_add     <= '0;
                    ram_data_in <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Scoreboard bench: a round-robin and a fixed-priority arbiter, each with its own RAM model,
// see identical master stimulus; a negedge monitor retires expected transactions on done.
module tb_ram_sp_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        m0_req, m0_we, m1_req, m1_we;
    logic [5:0]  m0_addr, m1_addr;
    logic [15:0] m0_wdata, m1_wdata;

    logic [1:0]       m0_gnt, m0_done, m1_gnt, m1_done;
    logic [1:0]       ram_r_w, ram_enable, ram_ce;
    logic [1:0][15:0] m0_rdata, m1_rdata, ram_data_in;
    logic [1:0][5:0]  ram_add;

    typedef struct {
        int          master;
        logic        is_read;
        logic [5:0]  addr;
        logic [15:0] data;
        int          cyc;
    } sb_t;

    sb_t q0[$];
    sb_t q1[$];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    int          en_cnt [2];
    logic [5:0]  en_addr [2];
    logic        en_rw [2];
    logic [15:0] en_din [2];
    logic [15:0] hold [2][2];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0 is round-robin, instance 1 is fixed priority; each owns a RAM model
    // whose contents start as 0x1000 + address.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [15:0] mem [64];
        logic [15:0] rdo = 16'h0;

        initial for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i);

        always @(posedge clk) begin
            if (ram_enable[g] && ram_ce[g]) begin
                if (ram_r_w[g]) mem[ram_add[g]] <= ram_data_in[g];
                else            rdo <= mem[ram_add[g]];
            end
        end

        ram_sp_arbiter #(.ADDR_W(6), .DATA_W(16), .ARB_MODE(g)) dut (
            .clk          (clk),
            .rst          (rst),
            .m0_req       (m0_req),
            .m0_we        (m0_we),
            .m0_addr      (m0_addr),
            .m0_wdata     (m0_wdata),
            .m0_gnt       (m0_gnt[g]),
            .m0_done      (m0_done[g]),
            .m0_rdata     (m0_rdata[g]),
            .m1_req       (m1_req),
            .m1_we        (m1_we),
            .m1_addr      (m1_addr),
            .m1_wdata     (m1_wdata),
            .m1_gnt       (m1_gnt[g]),
            .m1_done      (m1_done[g]),
            .m1_rdata     (m1_rdata[g]),
            .ram_add      (ram_add[g]),
            .ram_data_in  (ram_data_in[g]),
            .ram_r_w      (ram_r_w[g]),
            .ram_enable   (ram_enable[g]),
            .ram_ce       (ram_ce[g]),
            .ram_data_out (rdo)
        );
    end

    task automatic checkOutput(input string name, input int d, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s dut%0d: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, d, actual, expected, cyc);
        end
    endtask

    function automatic sb_t mk(input int master, input logic is_read, input logic [5:0] addr,
                               input logic [15:0] data, input int c);
        sb_t e;
        e.master  = master;
        e.is_read = is_read;
        e.addr    = addr;
        e.data    = data;
        e.cyc     = c;
        return e;
    endfunction

    task automatic pushBoth(input sb_t e);
        q0.push_back(e);
        q1.push_back(e);
    endtask

    task automatic setM(input int m, input logic req, input logic we, input logic [5:0] addr,
                        input logic [15:0] wdata);
        if (m == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    // One single-master transaction; the address input is rewritten to late_addr during ACCESS.
    task automatic applyStimulus(input int m, input logic we, input logic [5:0] addr,
                                 input logic [15:0] wdata, input logic [15:0] exp_rd,
                                 input logic [5:0] late_addr);
        @(negedge clk);
        setM(m, 1'b1, we, addr, wdata);
        pushBoth(mk(m, !we, addr, we ? wdata : exp_rd, cyc + 3));
        @(negedge clk);
        if (m == 0) m0_addr = late_addr;
        else        m1_addr = late_addr;
        repeat (2) @(negedge clk);
        setM(m, 1'b0, 1'b0, 6'h0, 16'h0);
        @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        setM(0, 1'b0, 1'b0, 6'h0, 16'h0);
        setM(1, 1'b0, 1'b0, 6'h0, 16'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic monitorDut(input int d);
        sb_t  e;
        int   m;
        logic empty;
        if (rst) begin
            en_cnt[d]  = 0;
            hold[d][0] = 16'h0;
            hold[d][1] = 16'h0;
            return;
        end
        if (m0_gnt[d] | m1_gnt[d])
            checkOutput("gnt_exclusive", d, 64'(m0_gnt[d] & m1_gnt[d]), 64'(0));
        if (ram_enable[d] | ram_ce[d])
            checkOutput("ce_eq_enable", d, 64'(ram_ce[d]), 64'(ram_enable[d]));
        if (ram_enable[d]) begin
            en_cnt[d]++;
            en_addr[d] = ram_add[d];
            en_rw[d]   = ram_r_w[d];
            en_din[d]  = ram_data_in[d];
        end
        if (m0_done[d] | m1_done[d]) begin
            checkOutput("single_done", d, 64'(m0_done[d] & m1_done[d]), 64'(0));
            m = m1_done[d] ? 1 : 0;
            empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_done dut%0d: got done from M%0d, expected none", d, m);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                checkOutput("done_master", d, 64'(m), 64'(e.master));
                checkOutput("done_cycle", d, 64'(cyc), 64'(e.cyc));
                checkOutput("enable_cycles", d, 64'(en_cnt[d]), 64'(1));
                checkOutput("ram_add", d, 64'(en_addr[d]), 64'(e.addr));
                checkOutput("ram_r_w", d, 64'(en_rw[d]), 64'(!e.is_read));
                if (!e.is_read) checkOutput("ram_data_in", d, 64'(en_din[d]), 64'(e.data));
                checkOutput("winner_gnt", d, 64'(m ? m1_gnt[d] : m0_gnt[d]), 64'(1));
                if (e.is_read) hold[d][m] = e.data;
                checkOutput("winner_rdata", d, 64'(m ? m1_rdata[d] : m0_rdata[d]), 64'(hold[d][m]));
                checkOutput("other_rdata", d, 64'(m ? m0_rdata[d] : m1_rdata[d]), 64'(hold[d][1-m]));
            end
            en_cnt[d] = 0;
        end
    endtask

    always @(negedge clk) begin
        monitorDut(0);
        monitorDut(1);
    end

    initial begin
        int n;
        setM(0, 1'b0, 1'b0, 6'h0, 16'h0);
        setM(1, 1'b0, 1'b0, 6'h0, 16'h0);
        for (int d = 0; d < 2; d++) begin
            en_cnt[d]  = 0;
            hold[d][0] = 16'h0;
            hold[d][1] = 16'h0;
        end
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++)
            checkOutput("reset_state", d, 64'({m0_gnt[d], m1_gnt[d], m0_done[d], m1_done[d],
                        m0_rdata[d], m1_rdata[d], ram_add[d], ram_data_in[d], ram_r_w[d],
                        ram_enable[d], ram_ce[d]}), 64'(0));
        rst = 1'b0;

        $display("[TB] write 0xBEEF to 0x05 then read it back on M0");
        applyStimulus(0, 1'b1, 6'h05, 16'hBEEF, 16'h0000, 6'h05);
        applyStimulus(0, 1'b0, 6'h05, 16'h0000, 16'hBEEF, 6'h05);

        $display("[TB] both masters requesting continuously from reset");
        doReset();
        @(negedge clk);
        n = cyc;
        setM(0, 1'b1, 1'b0, 6'h05, 16'h0);
        setM(1, 1'b1, 1'b0, 6'h03, 16'h0);
        q0.push_back(mk(0, 1'b1, 6'h05, 16'hBEEF, n + 3));
        q0.push_back(mk(1, 1'b1, 6'h03, 16'h1003, n + 7));
        q0.push_back(mk(0, 1'b1, 6'h05, 16'hBEEF, n + 11));
        q0.push_back(mk(1, 1'b1, 6'h03, 16'h1003, n + 15));
        for (int k = 0; k < 4; k++)
            q1.push_back(mk(0, 1'b1, 6'h05, 16'hBEEF, n + 3 + 4 * k));
        repeat (13) @(negedge clk);
        setM(0, 1'b0, 1'b0, 6'h0, 16'h0);
        setM(1, 1'b0, 1'b0, 6'h0, 16'h0);
        repeat (4) @(negedge clk);

        $display("[TB] M1 read 0x03 with address changed during ACCESS");
        applyStimulus(1, 1'b0, 6'h03, 16'h0000, 16'h1003, 6'h07);

        $display("[TB] reset pulsed during CAPTURE");
        @(negedge clk);
        setM(1, 1'b1, 1'b0, 6'h07, 16'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        setM(1, 1'b0, 1'b0, 6'h0, 16'h0);
        #1;
        for (int d = 0; d < 2; d++)
            checkOutput("reset_abort", d, 64'({m0_gnt[d], m1_gnt[d], m0_done[d], m1_done[d],
                        m0_rdata[d], m1_rdata[d], ram_add[d], ram_data_in[d], ram_r_w[d],
                        ram_enable[d], ram_ce[d]}), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        applyStimulus(1, 1'b0, 6'h07, 16'h0000, 16'h1007, 6'h07);

        $display("[TB] M0 request held across DONE");
        @(negedge clk);
        n = cyc;
        setM(0, 1'b1, 1'b0, 6'h05, 16'h0);
        pushBoth(mk(0, 1'b1, 6'h05, 16'hBEEF, n + 3));
        pushBoth(mk(0, 1'b1, 6'h05, 16'hBEEF, n + 7));
        repeat (4) @(negedge clk);
        for (int d = 0; d < 2; d++)
            checkOutput("idle_gap_gnt", d, 64'(m0_gnt[d]), 64'(0));
        @(negedge clk);
        setM(0, 1'b0, 1'b0, 6'h0, 16'h0);
        repeat (6) @(negedge clk);

        checkOutput("queue_drained", 0, 64'(q0.size()), 64'(0));
        checkOutput("queue_drained", 1, 64'(q1.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
